// File: rtl/core_pkg.sv
// Shared types for the data-memory store buffer: store sizes, FSM states, entry layout.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package core_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } st_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RDONE
    } sb_state_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } sb_entry_t;

    // Byte-lane enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input st_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return 4'b0011 << lo;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Halves must sit on even addresses, words on word boundaries.
    function automatic logic store_misaligned(input st_size_e sz, input logic [1:0] lo);
        return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer entry FIFO with a parallel word-address compare across all valid entries.
// Latency: push visible at head/hit the cycle after the push edge; head is combinational.
// Backpressure: caller must not push when full unless popping the same edge.
module sb_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        i_push,
    input  sb_entry_t   i_push_entry,
    input  logic        i_pop,
    input  logic [29:0] i_cmp_waddr,
    output logic        o_full,
    output logic        o_empty,
    output sb_entry_t   o_head,
    output logic        o_hit
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    sb_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_hit;

    // Entry storage; validity comes from the occupancy count, so no reset needed.
    always_ff @(posedge Clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - r_rd_ptr;
            if (({1'b0, off} < r_count) && (r_mem[i].waddr == i_cmp_waddr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_hit   = w_hit;

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between core and data memory; loads drain matching stores first.
// Latency: store 0 cycles to accept; load 3 cycles minimum (IDLE, READ, RDONE).
// Backpressure: Core_stall on store to a full buffer (unless head acks) and on every load until RDONE.
module dmem_store_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Core_addr,
    input  logic [1:0]  Core_we,
    input  logic [7:0]  Core_wr1,
    input  logic [7:0]  Core_wr2,
    input  logic [7:0]  Core_wr3,
    input  logic [7:0]  Core_wr4,
    input  logic        Core_rd_req,
    output logic [31:0] Core_rd_data,
    output logic        Core_stall,
    output logic        Misalign_err,
    output logic        Sb_empty,
    output logic        Mem_req,
    output logic        Mem_we,
    output logic [31:0] Mem_addr,
    output logic [3:0]  Mem_be,
    output logic [31:0] Mem_wdata,
    input  logic        Mem_ack,
    input  logic [31:0] Mem_rdata
);

    sb_state_e   r_state;
    logic [31:0] r_rd_data;

    st_size_e    w_size;
    logic        w_misalign;
    logic        w_store_vld;
    logic        w_head_ack;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic        w_hit;
    sb_entry_t   w_head;
    sb_entry_t   w_push_entry;

    assign w_size       = st_size_e'(Core_we);
    assign w_misalign   = store_misaligned(w_size, Core_addr[1:0]);
    assign w_store_vld  = (w_size != SZ_NONE) && !w_misalign;
    assign w_head_ack   = (r_state == ST_WRITE) && Mem_ack;
    // A full buffer still takes a store on the edge that retires its head.
    assign w_push       = w_store_vld && (!w_full || w_head_ack);
    assign w_push_entry = '{waddr: Core_addr[31:2],
                            be:    store_be(w_size, Core_addr[1:0]),
                            wdata: {Core_wr4, Core_wr3, Core_wr2, Core_wr1}};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_head_ack),
        .i_cmp_waddr  (Core_addr[31:2]),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head),
        .o_hit        (w_hit)
    );

    // Control FSM: loads win over draining unless a buffered store targets the load word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Core_rd_req && !w_hit) r_state <= ST_READ;
                    else if (!w_empty)         r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (Mem_ack) r_state <= ST_IDLE;
                end
                ST_READ: begin
                    if (Mem_ack) begin
                        r_rd_data <= Mem_rdata;
                        r_state   <= ST_RDONE;
                    end
                end
                ST_RDONE: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory request fields decode from the state register and the (stable) head entry.
    always_comb begin
        Mem_req   = 1'b0;
        Mem_we    = 1'b0;
        Mem_addr  = '0;
        Mem_be    = '0;
        Mem_wdata = '0;
        case (r_state)
            ST_WRITE: begin
                Mem_req   = 1'b1;
                Mem_we    = 1'b1;
                Mem_addr  = {w_head.waddr, 2'b00};
                Mem_be    = w_head.be;
                Mem_wdata = w_head.wdata;
            end
            ST_READ: begin
                Mem_req  = 1'b1;
                Mem_addr = {Core_addr[31:2], 2'b00};
                Mem_be   = 4'b1111;
            end
            default: ;
        endcase
    end

    assign Core_stall   = (w_store_vld && w_full && !w_head_ack) ||
                          (Core_rd_req && (r_state != ST_RDONE));
    // Gated by reset so the pulse cannot appear while the block is held in reset.
    assign Misalign_err = w_misalign && Reset_n;
    assign Sb_empty     = w_empty && (r_state == ST_IDLE);
    assign Core_rd_data = r_rd_data;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench: architectural memory model (stores applied in program order) plus an
// in-order queue of expected memory writes; a physical memory answers reads.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    logic        Clk, Reset_n;
    logic [31:0] core_addr;
    logic [1:0]  core_we;
    logic [7:0]  wr1, wr2, wr3, wr4;
    logic        core_rd_req;
    logic [31:0] core_rd_data;
    logic        core_stall, misalign_err, sb_empty;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] data;
    } st_t;

    st_t         exp_q[$];
    logic [31:0] phys_mem [1024];
    logic [31:0] arch_mem [1024];
    int total, bad, pushed, completed, n_writes, n_reads, req_cycles, ack_mode;
    st_t mon_e;
    bit  mon_hit;

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Core_addr(core_addr), .Core_we(core_we),
        .Core_wr1(wr1), .Core_wr2(wr2), .Core_wr3(wr3), .Core_wr4(wr4),
        .Core_rd_req(core_rd_req), .Core_rd_data(core_rd_data),
        .Core_stall(core_stall), .Misalign_err(misalign_err), .Sb_empty(sb_empty),
        .Mem_req(mem_req), .Mem_we(mem_we), .Mem_addr(mem_addr), .Mem_be(mem_be),
        .Mem_wdata(mem_wdata), .Mem_ack(mem_ack), .Mem_rdata(mem_rdata)
    );

    assign mem_rdata = phys_mem[mem_addr[11:2]];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Memory ack driver: 0 = always ack, 1 = never ack, 2 = random.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge Clk);
            #2;
            case (ack_mode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = 1'b0;
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Lane j is written when it lies inside [offset, offset+size).
    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
        int nb, lo;
        logic [3:0] be;
        nb = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
        lo = int'(a[1:0]);
        be = 4'b0000;
        for (int j = 0; j < 4; j++) if (j >= lo && j < lo + nb) be[j] = 1'b1;
        return be;
    endfunction

    function automatic bit exp_mis(input logic [31:0] a, input logic [1:0] sz);
        int nb;
        nb = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
        return (int'(a[1:0]) % nb) != 0;
    endfunction

    // Completed memory transactions are checked against the expected order.
    always @(negedge Clk) begin
        if (Reset_n === 1'b1) begin
            if (mem_req === 1'b1) req_cycles++;
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
                if (mem_we === 1'b1) begin
                    n_writes++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL write_unexpected addr=%h be=%b", mem_addr, mem_be);
                    end else begin
                        mon_e = exp_q.pop_front();
                        completed++;
                        if (mem_addr !== mon_e.waddr || mem_be !== mon_e.be || mem_wdata !== mon_e.data) begin
                            bad++;
                            $display("FAIL write_order got addr=%h be=%b data=%h exp addr=%h be=%b data=%h",
                                     mem_addr, mem_be, mem_wdata, mon_e.waddr, mon_e.be, mon_e.data);
                        end
                        for (int j = 0; j < 4; j++)
                            if (mon_e.be[j]) phys_mem[mon_e.waddr[11:2]][8*j +: 8] = mon_e.data[8*j +: 8];
                    end
                end else begin
                    n_reads++;
                    mon_hit = 1'b0;
                    foreach (exp_q[i]) if (exp_q[i].waddr == mem_addr) mon_hit = 1'b1;
                    total++;
                    if (mon_hit || mem_be !== 4'hF || mem_addr[1:0] !== 2'b00) begin
                        bad++;
                        $display("FAIL read_issue addr=%h be=%b pending_hit=%0d exp be=1111 no pending hit",
                                 mem_addr, mem_be, mon_hit);
                    end
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                            output int stalls);
        bit   mis, exp_stall, tmo;
        st_t  e;
        mis = exp_mis(a, sz);
        core_addr = a;
        core_we = sz;
        {wr4, wr3, wr2, wr1} = d;
        stalls = 0;
        tmo = 1'b0;
        @(negedge Clk); #1;
        total++;
        if (misalign_err !== mis) begin
            bad++;
            $display("FAIL store_misalign addr=%h sz=%0d got=%b exp=%b", a, sz, misalign_err, mis);
        end
        forever begin
            exp_stall = !mis && ((pushed - completed) == DEPTH);
            total++;
            if (core_stall !== exp_stall) begin
                bad++;
                $display("FAIL store_stall addr=%h got=%b exp=%b", a, core_stall, exp_stall);
            end
            if (core_stall !== 1'b1) break;
            stalls++;
            if (stalls > 200) begin
                tmo = 1'b1;
                bad++;
                $display("FAIL store_timeout addr=%h", a);
                break;
            end
            @(negedge Clk); #1;
        end
        if (!mis && !tmo) begin
            e.waddr = {a[31:2], 2'b00};
            e.be = exp_be(a, sz);
            e.data = d;
            exp_q.push_back(e);
            pushed++;
            for (int j = 0; j < 4; j++) if (e.be[j]) arch_mem[a[11:2]][8*j +: 8] = d[8*j +: 8];
        end
        @(posedge Clk); #1;
        core_we = 2'b00;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls, output logic [31:0] got);
        core_addr = a;
        core_rd_req = 1'b1;
        stalls = 0;
        @(negedge Clk); #1;
        while (core_stall === 1'b1 && stalls <= 200) begin
            stalls++;
            @(negedge Clk); #1;
        end
        got = core_rd_data;
        total++;
        if (stalls > 200) begin
            bad++;
            $display("FAIL load_timeout addr=%h", a);
        end else if (got !== arch_mem[a[11:2]]) begin
            bad++;
            $display("FAIL load_data addr=%h got=%h exp=%h", a, got, arch_mem[a[11:2]]);
        end
        @(posedge Clk); #1;
        core_rd_req = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input string tag);
        int n;
        n = 0;
        @(negedge Clk); #1;
        while (sb_empty !== 1'b1 && n < limit) begin
            n++;
            @(negedge Clk); #1;
        end
        total++;
        if (sb_empty !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_%s sb_empty=%b pending=%0d exp sb_empty=1 pending=0", tag, sb_empty, exp_q.size());
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total += 6;
        if (mem_req !== 1'b0)      begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        if (mem_we !== 1'b0)       begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        if (sb_empty !== 1'b1)     begin bad++; $display("FAIL reset_sb_empty got=%b exp=1", sb_empty); end
        if (core_rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", core_rd_data); end
        if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        if (core_stall !== 1'b0)   begin bad++; $display("FAIL reset_stall got=%b exp=0", core_stall); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk); #1;
        total += 2;
        if (sb_empty !== 1'b1) begin bad++; $display("FAIL post_reset_sb_empty got=%b exp=1", sb_empty); end
        if (mem_req !== 1'b0)  begin bad++; $display("FAIL post_reset_mem_req got=%b exp=0", mem_req); end
        @(posedge Clk); #1;
    endtask

    task automatic test_in_order();
        int st, w0;
        ack_mode = 0;
        w0 = n_writes;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h100 + 32'(4 * i), 2'd3, $urandom, st);
            total++;
            if (st != 0) begin bad++; $display("FAIL in_order_stall idx=%0d got=%0d exp=0", i, st); end
        end
        wait_drain(10, "in_order");
        total++;
        if (n_writes - w0 != 4) begin bad++; $display("FAIL in_order_writes got=%0d exp=4", n_writes - w0); end
    endtask

    task automatic test_full_stall();
        int st;
        ack_mode = 1;
        for (int i = 0; i < 4; i++) do_store(32'h140 + 32'(4 * i), 2'd3, $urandom, st);
        fork
            do_store(32'h150, 2'd3, $urandom, st);
            begin repeat (4) @(posedge Clk); #1; ack_mode = 0; end
        join
        ack_mode = 1;
        total++;
        if (st != 4) begin bad++; $display("FAIL full_stall_cycles got=%0d exp=4", st); end
        // Buffer must still hold four entries: a sixth store stalls until the next ack.
        fork
            do_store(32'h154, 2'd3, $urandom, st);
            begin repeat (2) @(posedge Clk); #1; ack_mode = 0; end
        join
        total++;
        if (st != 2) begin bad++; $display("FAIL full_occupancy_stall got=%0d exp=2", st); end
        wait_drain(40, "full");
    endtask

    task automatic test_hit_drain();
        int st, w0;
        logic [31:0] got;
        ack_mode = 0;
        w0 = n_writes;
        do_store(32'h203, 2'd1, {8'hAB, 24'($urandom)}, st);
        do_load(32'h200, st, got);
        total += 2;
        if (got[31:24] !== 8'hAB) begin bad++; $display("FAIL hit_byte got=%h exp=ab", got[31:24]); end
        if (n_writes - w0 != 1) begin bad++; $display("FAIL hit_write_first got=%0d exp=1", n_writes - w0); end
        wait_drain(10, "hit");
    endtask

    task automatic test_load_latency();
        int st;
        logic [31:0] got;
        ack_mode = 0;
        phys_mem[10'h0C0] = 32'hDEADBEEF;
        arch_mem[10'h0C0] = 32'hDEADBEEF;
        do_load(32'h300, st, got);
        total += 2;
        if (st != 2) begin bad++; $display("FAIL load_latency_stall got=%0d exp=2", st); end
        if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL load_latency_data got=%h exp=deadbeef", got); end
    endtask

    task automatic test_misalign();
        int st, r0;
        ack_mode = 0;
        r0 = req_cycles;
        do_store(32'h401, 2'd2, $urandom, st);
        @(negedge Clk); #1;
        total++;
        if (misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_pulse_width got=%b exp=0", misalign_err); end
        @(posedge Clk); #1;
        do_store(32'h10A, 2'd3, $urandom, st);
        repeat (4) @(posedge Clk);
        #1;
        total += 2;
        if (req_cycles != r0) begin bad++; $display("FAIL misalign_mem_req got=%0d exp=0", req_cycles - r0); end
        if (sb_empty !== 1'b1) begin bad++; $display("FAIL misalign_sb_empty got=%b exp=1", sb_empty); end
    endtask

    task automatic test_random();
        int op, st;
        logic [31:0] a, got;
        ack_mode = 2;
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 4);
            a = 32'h100 + 32'($urandom_range(0, 31));
            if (op == 0) do_load(a, st, got);
            else do_store(a, (op == 4) ? 2'd3 : 2'(op), $urandom, st);
        end
        ack_mode = 0;
        wait_drain(40, "random");
        for (int w = 10'h040; w < 10'h048; w++) begin
            total++;
            if (phys_mem[w] !== arch_mem[w]) begin
                bad++;
                $display("FAIL random_mem word=%h got=%h exp=%h", w, phys_mem[w], arch_mem[w]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int st, n, r0;
        ack_mode = 1;
        for (int i = 0; i < 3; i++) do_store(32'h180 + 32'(4 * i), 2'd3, $urandom, st);
        n = 0;
        @(negedge Clk); #1;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 20) begin
            n++;
            @(negedge Clk); #1;
        end
        Reset_n = 1'b0;
        #1;
        total += 3;
        if (n >= 20)           begin bad++; $display("FAIL reset_mid_no_write got=timeout exp=write"); end
        if (mem_req !== 1'b0)  begin bad++; $display("FAIL reset_mid_mem_req got=%b exp=0", mem_req); end
        if (sb_empty !== 1'b1) begin bad++; $display("FAIL reset_mid_sb_empty got=%b exp=1", sb_empty); end
        exp_q.delete();
        pushed = 0;
        completed = 0;
        for (int i = 0; i < 1024; i++) arch_mem[i] = phys_mem[i];
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        ack_mode = 0;
        r0 = req_cycles;
        repeat (10) @(posedge Clk);
        #1;
        total += 2;
        if (req_cycles != r0)  begin bad++; $display("FAIL reset_mid_traffic got=%0d exp=0", req_cycles - r0); end
        if (sb_empty !== 1'b1) begin bad++; $display("FAIL reset_mid_after got=%b exp=1", sb_empty); end
    endtask

    initial begin
        total = 0; bad = 0; pushed = 0; completed = 0;
        n_writes = 0; n_reads = 0; req_cycles = 0; ack_mode = 0;
        Reset_n = 1'b0;
        core_addr = '0; core_we = 2'b00; core_rd_req = 1'b0;
        wr1 = '0; wr2 = '0; wr3 = '0; wr4 = '0;
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = $urandom;
            arch_mem[i] = phys_mem[i];
        end
        test_reset();
        test_in_order();
        test_full_stall();
        test_hit_drain();
        test_load_latency();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, power of two in range 2..16; number of buffered store entries.
REQ-002 SHALL provide ports: Clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL provide ports: Reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide core-side inputs: Core_addr in 32 byte address; Core_we in 2 store size (00 none, 01 byte, 10 half, 11 word); Core_wr1..Core_wr4 in 8 each, aligned byte lanes 0..3; Core_rd_req in 1 load request.
REQ-005 SHALL provide core-side outputs: Core_rd_data out 32 load word; Core_stall out 1 core must hold all core-side inputs; Misalign_err out 1 one-cycle pulse; Sb_empty out 1 buffer empty and FSM idle.
REQ-006 SHALL provide memory-side ports: Mem_req out 1; Mem_we out 1; Mem_addr out 32 word-aligned; Mem_be out 4; Mem_wdata out 32; Mem_ack in 1; Mem_rdata in 32.

Function
REQ-007 Byte enables SHALL be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111; Mem_wdata = {wr4,wr3,wr2,wr1}.
REQ-008 Half with addr[0]=1 or word with addr[1:0]!=0 SHALL be dropped, not buffered, no stall, Misalign_err pulsed that cycle.
REQ-009 A valid store SHALL be pushed {addr[31:2],be,data} at the clock edge when buffer not full, or when full and head drain is acked that same edge.
REQ-010 Core_stall SHALL be combinational: (store valid AND full AND NOT head-ack this cycle) OR (Core_rd_req AND FSM not RDONE).
REQ-011 Core_rd_req and Core_we!=00 together SHALL never occur; behaviour then is undefined.
REQ-012 FSM states SHALL be IDLE, WRITE, READ, RDONE.
REQ-013 IDLE: load pending with no word-address hit in buffer -> READ; else buffer non-empty -> WRITE (head entry); else stay. Load priority over drain.
REQ-014 Load with word-address hit on any valid entry SHALL drain entries (WRITE) until no hit remains, then READ.
REQ-015 WRITE: Mem_req=1, Mem_we=1, fields from head entry, held stable until Mem_ack; on ack pop head, -> IDLE.
REQ-016 READ: Mem_req=1, Mem_we=0, Mem_addr={Core_addr[31:2],2'b00}, Mem_be=1111; on ack capture Mem_rdata, -> RDONE.
REQ-017 RDONE: Core_rd_data = captured word, Core_stall=0, -> IDLE unconditionally (one cycle).
REQ-018 Minimum load latency with same-cycle ack SHALL be 3 cycles (stall 2); store into non-full buffer SHALL never stall.
REQ-019 Mem_ack outside WRITE/READ SHALL be ignored.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; full/empty from an occupancy counter 0..DEPTH.
REQ-021 Entries SHALL drain in push order; no store merging, no store-to-load forwarding.

Reset
REQ-022 Reset_n low SHALL asynchronously force: FSM IDLE, occupancy 0, pointers 0, Mem_req 0, Mem_we 0, Core_rd_data 0, Misalign_err 0; Sb_empty 1.
REQ-023 Reset mid-transaction SHALL discard all buffered stores and the outstanding access; Mem_req low immediately.
REQ-024 Reset SHALL deassert synchronously to Clk at the block boundary (synchronizer external).

Structure
REQ-025 Store-size encodings and FSM state enum SHALL live in shared package core_pkg.
REQ-026 Entry storage and pointers SHALL be sub-module sb_fifo (push, pop, full, empty, head, parallel address-compare hit output).
REQ-027 No clock gating, no latches; storage not reset, valid tracked by occupancy.

Verification
REQ-028 Push 4 word stores to 0x100,0x104,0x108,0x10C, Mem_ack held 1 -> four WRITE transactions in order, be=1111, Sb_empty=1 after 8 cycles, no stall.
REQ-029 Fifth store with buffer full, Mem_ack=0 -> Core_stall=1 until first ack, store accepted on ack edge, occupancy remains 4.
REQ-030 Store byte 0xAB to 0x203 then load 0x200 -> WRITE be=1000 wdata[31:24]=0xAB precedes READ addr 0x200.
REQ-031 Load 0x300 no hit, Mem_ack same cycle, Mem_rdata=0xDEADBEEF -> Core_stall 2 cycles, Core_rd_data=0xDEADBEEF in RDONE.
REQ-032 Half store to 0x401 -> Misalign_err one-cycle pulse, no push, no Mem_req.
REQ-033 Reset_n low during WRITE with 3 entries -> Mem_req 0 same cycle, Sb_empty 1, no further memory traffic after release.
